pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_gen_ras.sv | 79 +++++++
 rtl/pc_gen.sv | 93 +++++++++
 tb/tb_pc_gen.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator.
//   pc_sel_e         : which source feeds the next PC
//   INSTR_ALIGN_MASK : low PC bits that must be zero for a legal target
//   INSTR_BYTES      : sequential PC increment
//   isMisaligned()   : true when a target violates instruction alignment
package pc_pkg;

  typedef enum logic [2:0] {
    PC_TRAP,
    PC_HOLD,
    PC_RET,
    PC_COND,
    PC_SEQ
  } pc_sel_e;

  localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;
  localparam int unsigned INSTR_BYTES = 4;

  function automatic logic isMisaligned(input logic [1:0] lowBits);
    return (lowBits & INSTR_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// Return-address stack, circular buffer of RAS_DEPTH entries.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   push       : write push_data as the new top
//   pop        : discard the top entry (ignored when empty)
//   push_data  : return address to store
//   top        : current top entry (combinational read of storage)
//   empty/full : registered occupancy flags
// push and pop together replace the top in place. Pushing when full
// overwrites the oldest entry, which is the slot just above the top.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  entries [RAS_DEPTH];
  logic [PTR_W-1:0] topPtr, nextPtr, writePtr;
  logic [CNT_W-1:0] count, nextCount;
  logic             writeEn;

  // Next pointer/count and the storage write port for this cycle.
  always_comb begin
    nextPtr   = topPtr;
    nextCount = count;
    writePtr  = topPtr;
    writeEn   = 1'b0;
    if (push && pop && count != '0) begin
      writeEn = 1'b1;
    end else if (push) begin
      nextPtr  = topPtr + 1'b1;
      writePtr = topPtr + 1'b1;
      writeEn  = 1'b1;
      if (count != DEPTH_CNT) begin
        nextCount = count + 1'b1;
      end
    end else if (pop && count != '0) begin
      nextPtr   = topPtr - 1'b1;
      nextCount = count - 1'b1;
    end
  end

  // Pointer, count and flags; reset empties the stack logically.
  always_ff @(posedge clk) begin
    if (rst) begin
      topPtr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      topPtr <= nextPtr;
      count  <= nextCount;
      empty  <= (nextCount == '0);
      full   <= (nextCount == DEPTH_CNT);
    end
  end

  // Entry storage is never cleared; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (writeEn && !rst) begin
      entries[writePtr] <= push_data;
    end
  end

  assign top = entries[topPtr];

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with trap/branch redirect and return-address stack.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   clkEn             : advance enable, 0 stalls
//   trapEn, trap_vec  : trap redirect (overrides stall)
//   condEn, next_pc_cond : branch/jump redirect
//   call_push         : push pc_out+4 onto the RAS
//   ret_pop           : redirect to RAS top and pop
//   pc_out            : registered current PC
//   pc_misaligned     : one-cycle pulse after a rejected target
//   ras_empty/ras_full: registered RAS occupancy
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clkEn,
  input  logic            trapEn,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            condEn,
  input  logic [XLEN-1:0] next_pc_cond,
  input  logic            call_push,
  input  logic            ret_pop,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_misaligned,
  output logic            ras_empty,
  output logic            ras_full
);

  pc_sel_e         pcSel;
  logic [XLEN-1:0] seqPc, target, nextPc, rasTop;
  logic            retValid, checkAlign, misaligned, advance;

  assign seqPc    = pc_out + XLEN'(INSTR_BYTES);
  assign retValid = ret_pop && !ras_empty;

  // Priority select; a pop on an empty stack falls through to cond/seq.
  always_comb begin
    pcSel = PC_SEQ;
    if (trapEn)        pcSel = PC_TRAP;
    else if (!clkEn)   pcSel = PC_HOLD;
    else if (retValid) pcSel = PC_RET;
    else if (condEn)   pcSel = PC_COND;
  end

  // Target mux and alignment check; a misaligned target holds the PC.
  always_comb begin
    target     = pc_out;
    checkAlign = 1'b0;
    unique case (pcSel)
      PC_TRAP: begin target = trap_vec;     checkAlign = 1'b1; end
      PC_RET:  begin target = rasTop;       checkAlign = 1'b1; end
      PC_COND: begin target = next_pc_cond; checkAlign = 1'b1; end
      PC_SEQ:  target = seqPc;
      default: target = pc_out;
    endcase
    misaligned = checkAlign && isMisaligned(target[1:0]);
    nextPc     = misaligned ? pc_out : target;
  end

  // RAS only moves on a clean, non-trap advance.
  assign advance = clkEn && !trapEn && !misaligned;

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (advance && call_push),
    .pop       (advance && retValid),
    .push_data (seqPc),
    .top       (rasTop),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // PC register and the misalignment pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out        <= RESET_VECTOR;
      pc_misaligned <= 1'b0;
    end else begin
      pc_out        <= nextPc;
      pc_misaligned <= misaligned;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: each stimulus cycle queues the hand-computed
// state expected after the next rising edge; a monitor compares it.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clkEn = 1'b0;
  logic        trapEn = 1'b0;
  logic [31:0] trapVec = '0;
  logic        condEn = 1'b0;
  logic [31:0] condPc = '0;
  logic        callPush = 1'b0;
  logic        retPop = 1'b0;
  logic [31:0] pcOut;
  logic        pcMis, rasEmpty, rasFull;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        mis;
    logic        emp;
    logic        full;
  } exp_t;

  exp_t scoreboard[$];
  exp_t monEntry;
  int   checksTotal  = 0;
  int   checksPassed = 0;

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0),
    .RAS_DEPTH    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clkEn         (clkEn),
    .trapEn        (trapEn),
    .trap_vec      (trapVec),
    .condEn        (condEn),
    .next_pc_cond  (condPc),
    .call_push     (callPush),
    .ret_pop       (retPop),
    .pc_out        (pcOut),
    .pc_misaligned (pcMis),
    .ras_empty     (rasEmpty),
    .ras_full      (rasFull)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input string field,
                             input logic [31:0] got, input logic [31:0] exp);
    checksTotal++;
    if (got === exp) checksPassed++;
    else $display("[TB] FAIL %s %s: got %h expected %h", name, field, got, exp);
  endtask

  task automatic applyStimulus(input string name, input logic r, input logic en,
                               input logic tr, input logic [31:0] tv,
                               input logic ce, input logic [31:0] cp,
                               input logic pu, input logic po,
                               input logic [31:0] ePc, input logic eMis,
                               input logic eEmp, input logic eFull);
    exp_t e;
    @(negedge clk);
    rst = r; clkEn = en; trapEn = tr; trapVec = tv;
    condEn = ce; condPc = cp; callPush = pu; retPop = po;
    e.name = name; e.pc = ePc; e.mis = eMis; e.emp = eEmp; e.full = eFull;
    scoreboard.push_back(e);
  endtask

  // Monitor: compare one queued expectation after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (scoreboard.size() != 0) begin
        monEntry = scoreboard.pop_front();
        checkOutput(monEntry.name, "pc_out", pcOut, monEntry.pc);
        checkOutput(monEntry.name, "pc_misaligned", {31'b0, pcMis}, {31'b0, monEntry.mis});
        checkOutput(monEntry.name, "ras_empty", {31'b0, rasEmpty}, {31'b0, monEntry.emp});
        checkOutput(monEntry.name, "ras_full", {31'b0, rasFull}, {31'b0, monEntry.full});
      end
    end
  end

  initial begin
    //            name         rst en tr trapVec      ce condPc       pu po  expPc        mis emp full
    applyStimulus("reset",      1, 0, 0, 32'h0,      0, 32'h0,       0, 0, 32'h0,        0, 1, 0);
    applyStimulus("seq1",       0, 1, 0, 32'h0,      0, 32'h0,       0, 0, 32'h4,        0, 1, 0);
    applyStimulus("seq2",       0, 1, 0, 32'h0,      0, 32'h0,       0, 0, 32'h8,        0, 1, 0);
    applyStimulus("seq3",       0, 1, 0, 32'h0,      0, 32'h0,       0, 0, 32'hC,        0, 1, 0);
    applyStimulus("stallCond",  0, 0, 0, 32'h0,      1, 32'h100,     0, 0, 32'hC,        0, 1, 0);
    applyStimulus("trapStall",  0, 0, 1, 32'h200,    0, 32'h0,       0, 0, 32'h200,      0, 1, 0);
    applyStimulus("jumpTo10",   0, 1, 0, 32'h0,      1, 32'h10,      0, 0, 32'h10,       0, 1, 0);
    applyStimulus("call80",     0, 1, 0, 32'h0,      1, 32'h80,      1, 0, 32'h80,       0, 0, 0);
    applyStimulus("seq84",      0, 1, 0, 32'h0,      0, 32'h0,       0, 0, 32'h84,       0, 0, 0);
    applyStimulus("ret14",      0, 1, 0, 32'h0,      0, 32'h0,       0, 1, 32'h14,       0, 1, 0);
    applyStimulus("push1",      0, 1, 0, 32'h0,      1, 32'h1000,    1, 0, 32'h1000,     0, 0, 0);
    applyStimulus("push2",      0, 1, 0, 32'h0,      1, 32'h2000,    1, 0, 32'h2000,     0, 0, 0);
    applyStimulus("push3",      0, 1, 0, 32'h0,      1, 32'h3000,    1, 0, 32'h3000,     0, 0, 0);
    applyStimulus("push4",      0, 1, 0, 32'h0,      1, 32'h4000,    1, 0, 32'h4000,     0, 0, 1);
    applyStimulus("push5",      0, 1, 0, 32'h0,      1, 32'h5000,    1, 0, 32'h5000,     0, 0, 1);
    applyStimulus("pop1",       0, 1, 0, 32'h0,      0, 32'h0,       0, 1, 32'h4004,     0, 0, 0);
    applyStimulus("pop2",       0, 1, 0, 32'h0,      0, 32'h0,       0, 1, 32'h3004,     0, 0, 0);
    applyStimulus("pop3",       0, 1, 0, 32'h0,      0, 32'h0,       0, 1, 32'h2004,     0, 0, 0);
    applyStimulus("pop4",       0, 1, 0, 32'h0,      0, 32'h0,       0, 1, 32'h1004,     0, 1, 0);
    applyStimulus("pop5Empty",  0, 1, 0, 32'h0,      0, 32'h0,       0, 1, 32'h1008,     0, 1, 0);
    applyStimulus("misCond",    0, 1, 0, 32'h0,      1, 32'h102,     1, 0, 32'h1008,     1, 1, 0);
    applyStimulus("misClear",   0, 1, 0, 32'h0,      0, 32'h0,       0, 0, 32'h100C,     0, 1, 0);
    applyStimulus("stallMis",   0, 0, 0, 32'h0,      1, 32'h102,     0, 0, 32'h100C,     0, 1, 0);
    applyStimulus("trapPrio",   0, 1, 1, 32'h300,    1, 32'h500,     1, 1, 32'h300,      0, 1, 0);
    applyStimulus("jumpTop",    0, 1, 0, 32'h0,      1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 0, 1, 0);
    applyStimulus("wrap",       0, 1, 0, 32'h0,      0, 32'h0,       0, 0, 32'h0,        0, 1, 0);
    applyStimulus("call40",     0, 1, 0, 32'h0,      1, 32'h40,      1, 0, 32'h40,       0, 0, 0);
    applyStimulus("retCall",    0, 1, 0, 32'h0,      0, 32'h0,       1, 1, 32'h4,        0, 0, 0);
    applyStimulus("retRepl",    0, 1, 0, 32'h0,      0, 32'h0,       0, 1, 32'h44,       0, 1, 0);
    applyStimulus("call40b",    0, 1, 0, 32'h0,      1, 32'h40,      1, 0, 32'h40,       0, 0, 0);
    applyStimulus("stallPop",   0, 0, 0, 32'h0,      0, 32'h0,       0, 1, 32'h40,       0, 0, 0);
    applyStimulus("rstPush",    1, 1, 0, 32'h0,      1, 32'h80,      1, 0, 32'h0,        0, 1, 0);
    applyStimulus("popAfterRst",0, 1, 0, 32'h0,      0, 32'h0,       0, 1, 32'h4,        0, 1, 0);

    for (int i = 0; i < 20 && scoreboard.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (scoreboard.size() != 0) begin
      checksTotal++;
      $display("[TB] FAIL drain: got %0d pending expected 0", scoreboard.size());
    end
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
